// File: rtl/dma_ctrl_if.sv
// Bus-side signal bundle for dma_ctrl: slave register port plus master copy port.
// The slave modport is the controller's view; master is the bus fabric's view.
interface dma_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              S_sel;
  logic              S_wr;
  logic [ADDR_W-1:0] S_address;
  logic [DATA_W-1:0] S_din;
  logic [DATA_W-1:0] S_dout;
  logic              M_req;
  logic              M_grant;
  logic              M_wr;
  logic [ADDR_W-1:0] M_address;
  logic [DATA_W-1:0] M_dout;
  logic [DATA_W-1:0] M_din;

  modport slave (
    input  S_sel, S_wr, S_address, S_din, M_grant, M_din,
    output S_dout, M_req, M_wr, M_address, M_dout
  );

  modport master (
    output S_sel, S_wr, S_address, S_din, M_grant, M_din,
    input  S_dout, M_req, M_wr, M_address, M_dout
  );
endinterface

// File: rtl/dma_ctrl.sv
// Single-channel DMA controller: programmed over the slave port, copies words as bus master.
// Define DMAC_INTR_EN to enable the INTR/INTR_EN registers and the interrupt output.
module dma_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic      clk,
  input  logic      reset_n,
  dma_ctrl_if.slave bus,
  output logic      interrupt
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRead,
    StLatch,
    StWrite,
    StDone
  } state_e;

  localparam logic [3:0] AddrOpstart = 4'h0;
  localparam logic [3:0] AddrIntr    = 4'h1;
  localparam logic [3:0] AddrIntrEn  = 4'h2;
  localparam logic [3:0] AddrSrc     = 4'h3;
  localparam logic [3:0] AddrDest    = 4'h4;
  localparam logic [3:0] AddrSize    = 4'h5;
  localparam logic [3:0] AddrStatus  = 4'h6;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_src_q, cnt_src_d, cnt_dst_q, cnt_dst_d;
  logic [7:0]        size_q, size_d, cnt_rem_q, cnt_rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] s_dout_q, s_dout_d;
  logic [DATA_W-1:0] rdata;

  logic       wr_en, rd_en, busy, start, set_done;
  logic [3:0] reg_addr;

  logic              m_req, m_wr;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_dout;

  assign reg_addr = bus.S_address[3:0];
  assign wr_en    = bus.S_sel & bus.S_wr;
  assign rd_en    = bus.S_sel & ~bus.S_wr;
  assign busy     = (state_q != StIdle);
  // Zero-size starts are dropped here so the FSM never leaves idle for them.
  assign start    = wr_en & ~busy & (reg_addr == AddrOpstart) & bus.S_din[0] & (size_q != 8'd0);

  // Programming registers; locked while a transfer is in flight.
  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    size_d = size_q;
    if (wr_en && !busy) begin
      case (reg_addr)
        AddrSrc:  src_d  = bus.S_din[ADDR_W-1:0];
        AddrDest: dst_d  = bus.S_din[ADDR_W-1:0];
        AddrSize: size_d = bus.S_din[7:0];
        default:  ;
      endcase
    end
  end

`ifdef DMAC_INTR_EN
  logic done_q, done_d, intr_en_q, intr_en_d;

  always_comb begin
    done_d    = done_q;
    intr_en_d = intr_en_q;
    if (wr_en && (reg_addr == AddrIntr) && !bus.S_din[0]) begin
      done_d = 1'b0;
    end
    if (wr_en && (reg_addr == AddrIntrEn)) begin
      intr_en_d = bus.S_din[0];
    end
    // Completion beats a simultaneous software clear.
    if (set_done) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      intr_en_q <= 1'b0;
    end else begin
      done_q    <= done_d;
      intr_en_q <= intr_en_d;
    end
  end

  assign interrupt = done_q & intr_en_q;
`else
  assign interrupt = 1'b0;
`endif

  // Transfer FSM and master-port outputs.
  always_comb begin
    state_d   = state_q;
    cnt_src_d = cnt_src_q;
    cnt_dst_d = cnt_dst_q;
    cnt_rem_d = cnt_rem_q;
    data_d    = data_q;
    set_done  = 1'b0;
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_address = '0;
    m_dout    = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StReq;
          cnt_src_d = src_q;
          cnt_dst_d = dst_q;
          cnt_rem_d = size_q;
        end
      end
      StReq: begin
        m_req = 1'b1;
        if (bus.M_grant) begin
          state_d = StRead;
        end
      end
      StRead: begin
        m_req     = 1'b1;
        m_address = cnt_src_q;
        if (bus.M_grant) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        m_req = 1'b1;
        if (bus.M_grant) begin
          data_d  = bus.M_din;
          state_d = StWrite;
        end
      end
      StWrite: begin
        m_req     = 1'b1;
        m_wr      = 1'b1;
        m_address = cnt_dst_q;
        m_dout    = data_q;
        if (bus.M_grant) begin
          cnt_src_d = cnt_src_q + 1'b1;
          cnt_dst_d = cnt_dst_q + 1'b1;
          cnt_rem_d = cnt_rem_q - 8'd1;
          state_d   = (cnt_rem_q == 8'd1) ? StDone : StRead;
        end
      end
      StDone: begin
        set_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Slave read mux; S_dout holds its last value between reads.
  always_comb begin
    rdata = '0;
    case (reg_addr)
`ifdef DMAC_INTR_EN
      AddrIntr:   rdata = DATA_W'(done_q);
      AddrIntrEn: rdata = DATA_W'(intr_en_q);
`endif
      AddrSrc:    rdata = DATA_W'(src_q);
      AddrDest:   rdata = DATA_W'(dst_q);
      AddrSize:   rdata = DATA_W'(size_q);
      AddrStatus: rdata = DATA_W'(busy);
      default:    rdata = '0;
    endcase
    s_dout_d = rd_en ? rdata : s_dout_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      size_q    <= '0;
      cnt_src_q <= '0;
      cnt_dst_q <= '0;
      cnt_rem_q <= '0;
      data_q    <= '0;
      s_dout_q  <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      size_q    <= size_d;
      cnt_src_q <= cnt_src_d;
      cnt_dst_q <= cnt_dst_d;
      cnt_rem_q <= cnt_rem_d;
      data_q    <= data_d;
      s_dout_q  <= s_dout_d;
    end
  end

  assign bus.S_dout    = s_dout_q;
  assign bus.M_req     = m_req;
  assign bus.M_wr      = m_wr;
  assign bus.M_address = m_address;
  assign bus.M_dout    = m_dout;

  logic unused;
`ifdef DMAC_INTR_EN
  assign unused = ^{bus.S_din[DATA_W-1:8], bus.S_address[ADDR_W-1:4]};
`else
  assign unused = ^{bus.S_din[DATA_W-1:8], bus.S_address[ADDR_W-1:4], set_done, AddrIntr,
                    AddrIntrEn};
`endif

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: register access, copies, wrap, grant stall, busy lock, reset.
// Interrupt expectations follow DMAC_INTR_EN the same way the design does.
module tb_dma_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic interrupt;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [256];
  logic [31:0] rd_data = '0;

  dma_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  dma_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  // Bus memory: read data returns one cycle after a granted read address and holds.
  assign bus.M_din = rd_data;
  always @(posedge clk) begin
    if (bus.M_req && bus.M_grant && !bus.M_wr) rd_data <= mem[bus.M_address];
    if (bus.M_req && bus.M_grant && bus.M_wr) mem[bus.M_address] = bus.M_dout;
  end

`ifdef DMAC_INTR_EN
  localparam logic IntrOn = 1'b1;
`else
  localparam logic IntrOn = 1'b0;
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    bus.S_sel = 1'b1; bus.S_wr = 1'b1; bus.S_address = {4'h0, a}; bus.S_din = d;
    tick();
    bus.S_sel = 1'b0; bus.S_wr = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
    bus.S_sel = 1'b1; bus.S_wr = 1'b0; bus.S_address = {4'h0, a};
    tick();
    bus.S_sel = 1'b0;
    d = bus.S_dout;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    bus.S_sel = 1'b1; bus.S_wr = 1'b1; bus.S_address = 8'h00; bus.S_din = 32'hFFFF_FFFF;
    bus.M_grant = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.S_dout, bus.M_req, bus.M_wr, bus.M_address, bus.M_dout, interrupt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sdout=%h req=%b wr=%b addr=%h mdout=%h irq=%b, want all 0",
               bus.S_dout, bus.M_req, bus.M_wr, bus.M_address, bus.M_dout, interrupt);
    end
    bus.S_sel = 1'b0; bus.S_wr = 1'b0;
    reset_n = 1'b1;
    read_reg(4'h6, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", rd); end
    read_reg(4'h5, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_size: got %h want 0", rd); end
  endtask

  task automatic test_single_word();
    logic [31:0] rd;
    mem[8'h10] = 32'hDEAD_BEEF;
    mem[8'h20] = 32'h0;
    write_reg(4'h3, 32'h0000_0010);
    write_reg(4'h4, 32'h0000_0020);
    write_reg(4'h5, 32'h0000_0001);
    write_reg(4'h2, 32'h0000_0001);
    write_reg(4'h9, 32'h0000_00FF);
    read_reg(4'h3, rd);
    checks++;
    if (rd !== 32'h10) begin errors++; $display("FAIL src_readback: got %h want 10", rd); end
    read_reg(4'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL opstart_reads0: got %h want 0", rd); end
    read_reg(4'h9, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL undef_reads0: got %h want 0", rd); end
    read_reg(4'h2, rd);
    checks++;
    if (rd !== {31'h0, IntrOn}) begin
      errors++; $display("FAIL intr_en_readback: got %h want %h", rd, IntrOn);
    end
    write_reg(4'h0, 32'h1);  // cycle T; now at T+1
    checks++;
    if (bus.M_req !== 1'b1 || bus.M_wr !== 1'b0) begin
      errors++; $display("FAIL single_req: got req=%b wr=%b want 1 0", bus.M_req, bus.M_wr);
    end
    tick();  // T+2 read
    checks++;
    if (bus.M_req !== 1'b1 || bus.M_wr !== 1'b0 || bus.M_address !== 8'h10) begin
      errors++;
      $display("FAIL single_read: got req=%b wr=%b addr=%h want 1 0 10",
               bus.M_req, bus.M_wr, bus.M_address);
    end
    tick();  // T+3 latch
    tick();  // T+4 write
    checks++;
    if (bus.M_wr !== 1'b1 || bus.M_address !== 8'h20 || bus.M_dout !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write: got wr=%b addr=%h dout=%h want 1 20 deadbeef",
               bus.M_wr, bus.M_address, bus.M_dout);
    end
    tick();  // T+5 done state
    checks++;
    if (bus.M_req !== 1'b0 || interrupt !== 1'b0) begin
      errors++; $display("FAIL single_t5: got req=%b irq=%b want 0 0", bus.M_req, interrupt);
    end
    tick();  // T+6
    checks++;
    if (interrupt !== IntrOn || bus.M_req !== 1'b0) begin
      errors++; $display("FAIL single_irq: got irq=%b req=%b want %b 0", interrupt, bus.M_req, IntrOn);
    end
    checks++;
    if (mem[8'h20] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_mem: got %h want deadbeef", mem[8'h20]);
    end
    read_reg(4'h1, rd);
    checks++;
    if (rd !== {31'h0, IntrOn}) begin errors++; $display("FAIL intr_flag: got %h want %h", rd, IntrOn); end
    write_reg(4'h1, 32'h0);
    checks++;
    if (interrupt !== 1'b0) begin errors++; $display("FAIL intr_clear: got %b want 0", interrupt); end
    read_reg(4'h6, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL single_busy: got %h want 0", rd); end
  endtask

  task automatic test_multi_wrap();
    logic [31:0] exp_data [4];
    logic [7:0]  sa, da;
    exp_data[0] = 32'hA0A0_0001; exp_data[1] = 32'hB1B1_0002;
    exp_data[2] = 32'hC2C2_0003; exp_data[3] = 32'hD3D3_0004;
    mem[8'hFE] = exp_data[0]; mem[8'hFF] = exp_data[1];
    mem[8'h00] = exp_data[2]; mem[8'h01] = exp_data[3];
    write_reg(4'h3, 32'hFE);
    write_reg(4'h4, 32'h40);
    write_reg(4'h5, 32'h4);
    write_reg(4'h0, 32'h1);  // at T+1
    for (int k = 0; k < 4; k++) begin
      sa = 8'(8'hFE + k);
      da = 8'(8'h40 + k);
      tick();  // T+2+3k read
      checks++;
      if (bus.M_wr !== 1'b0 || bus.M_address !== sa || bus.M_req !== 1'b1) begin
        errors++;
        $display("FAIL wrap_read%0d: got req=%b wr=%b addr=%h want 1 0 %h",
                 k, bus.M_req, bus.M_wr, bus.M_address, sa);
      end
      tick();
      tick();  // T+4+3k write
      checks++;
      if (bus.M_wr !== 1'b1 || bus.M_address !== da || bus.M_dout !== exp_data[k]) begin
        errors++;
        $display("FAIL wrap_write%0d: got wr=%b addr=%h dout=%h want 1 %h %h",
                 k, bus.M_wr, bus.M_address, bus.M_dout, da, exp_data[k]);
      end
    end
    tick();  // T+14 done state
    checks++;
    if (bus.M_req !== 1'b0) begin errors++; $display("FAIL wrap_req_low: got %b want 0", bus.M_req); end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[8'h40 + k] !== exp_data[k]) begin
        errors++; $display("FAIL wrap_mem%0d: got %h want %h", k, mem[8'h40 + k], exp_data[k]);
      end
    end
    write_reg(4'h1, 32'h0);
  endtask

  task automatic test_grant_stall();
    mem[8'h50] = 32'h1111_1111;
    mem[8'h51] = 32'h2222_2222;
    write_reg(4'h3, 32'h50);
    write_reg(4'h4, 32'h60);
    write_reg(4'h5, 32'h2);
    write_reg(4'h0, 32'h1);  // at T+1
    tick();
    tick();  // T+3 latch
    bus.M_grant = 1'b0;
    tick();  // T+4 stalled
    checks++;
    if (bus.M_req !== 1'b1 || bus.M_wr !== 1'b0 || bus.M_address !== 8'h00) begin
      errors++;
      $display("FAIL stall_hold: got req=%b wr=%b addr=%h want 1 0 00",
               bus.M_req, bus.M_wr, bus.M_address);
    end
    tick();  // T+5 stalled
    bus.M_grant = 1'b1;
    checks++;
    if (bus.M_wr !== 1'b0) begin errors++; $display("FAIL stall_hold2: got wr=%b want 0", bus.M_wr); end
    tick();  // T+6 write
    checks++;
    if (bus.M_wr !== 1'b1 || bus.M_address !== 8'h60 || bus.M_dout !== 32'h1111_1111) begin
      errors++;
      $display("FAIL stall_write: got wr=%b addr=%h dout=%h want 1 60 11111111",
               bus.M_wr, bus.M_address, bus.M_dout);
    end
    tick();  // T+7 read word 2
    checks++;
    if (bus.M_address !== 8'h51) begin
      errors++; $display("FAIL stall_read2: got %h want 51", bus.M_address);
    end
    tick();
    tick();  // T+9 write word 2
    checks++;
    if (bus.M_wr !== 1'b1 || bus.M_address !== 8'h61 || bus.M_dout !== 32'h2222_2222) begin
      errors++;
      $display("FAIL stall_write2: got wr=%b addr=%h dout=%h want 1 61 22222222",
               bus.M_wr, bus.M_address, bus.M_dout);
    end
    tick();  // T+10 done state
    checks++;
    if (bus.M_req !== 1'b0) begin errors++; $display("FAIL stall_req_low: got %b want 0", bus.M_req); end
    tick();  // T+11
    checks++;
    if (interrupt !== IntrOn) begin
      errors++; $display("FAIL stall_irq: got %b want %b", interrupt, IntrOn);
    end
    write_reg(4'h1, 32'h0);
  endtask

  task automatic test_busy_protect();
    logic [31:0] rd;
    int polls;
    for (int k = 0; k < 3; k++) mem[8'h70 + k] = 32'h7000_0000 + k;
    write_reg(4'h3, 32'h70);
    write_reg(4'h4, 32'h80);
    write_reg(4'h5, 32'h3);
    write_reg(4'h0, 32'h1);  // T
    write_reg(4'h3, 32'h99);
    write_reg(4'h5, 32'h07);
    write_reg(4'h4, 32'h01);
    write_reg(4'h0, 32'h1);  // now at T+5
    polls = 0;
    rd = 32'h1;
    while (rd !== 32'h0 && polls < 40) begin
      read_reg(4'h6, rd);
      polls++;
    end
    checks++;
    if (polls != 8) begin errors++; $display("FAIL busy_polls: got %0d want 8", polls); end
    read_reg(4'h3, rd);
    checks++;
    if (rd !== 32'h70) begin errors++; $display("FAIL busy_src: got %h want 70", rd); end
    read_reg(4'h5, rd);
    checks++;
    if (rd !== 32'h3) begin errors++; $display("FAIL busy_size: got %h want 3", rd); end
    read_reg(4'h4, rd);
    checks++;
    if (rd !== 32'h80) begin errors++; $display("FAIL busy_dest: got %h want 80", rd); end
    checks++;
    if (mem[8'h82] !== 32'h7000_0002) begin
      errors++; $display("FAIL busy_mem: got %h want 70000002", mem[8'h82]);
    end
    write_reg(4'h1, 32'h0);
  endtask

  task automatic test_size_zero();
    logic [31:0] rd;
    int req_seen;
    write_reg(4'h5, 32'h0);
    write_reg(4'h0, 32'h1);
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.M_req !== 1'b0) req_seen++;
      tick();
    end
    checks++;
    if (req_seen != 0) begin errors++; $display("FAIL size0_req: got %0d cycles want 0", req_seen); end
    read_reg(4'h1, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL size0_flag: got %h want 0", rd); end
    read_reg(4'h6, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL size0_busy: got %h want 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    write_reg(4'h3, 32'h00);
    write_reg(4'h4, 32'h90);
    write_reg(4'h5, 32'h4);
    write_reg(4'h0, 32'h1);  // at T+1
    repeat (6) tick();       // T+7 write of word 2
    checks++;
    if (bus.M_wr !== 1'b1 || bus.M_address !== 8'h91) begin
      errors++; $display("FAIL rst_mid_write: got wr=%b addr=%h want 1 91", bus.M_wr, bus.M_address);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if (bus.M_req !== 1'b0 || bus.M_wr !== 1'b0) begin
      errors++; $display("FAIL rst_mid_req: got req=%b wr=%b want 0 0", bus.M_req, bus.M_wr);
    end
    reset_n = 1'b1;
    read_reg(4'h6, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_busy: got %h want 0", rd); end
    read_reg(4'h4, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_dest: got %h want 0", rd); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.S_sel = 1'b0; bus.S_wr = 1'b0; bus.S_address = '0; bus.S_din = '0;
    bus.M_grant = 1'b1;
    tick();
    test_reset();
    test_single_word();
    test_multi_wrap();
    test_grant_stall();
    test_busy_protect();
    test_size_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
